// File: rtl/gs232c_jtb.sv
// gs232c_jtb: path-indexed indirect-jump target buffer with registered fetch-time prediction.
// Storage is flops; valid/conf are reset, tag/target are not.
module gs232c_jtb #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6,
  parameter int TAG_W   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_go,
  input  logic        fe_valid,
  input  logic [31:0] fe_pc,
  input  logic [63:0] hr_path_bt,
  input  logic        br_cancel,
  input  logic        wb_cancel,
  input  logic        br_jrop,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_target,
  input  logic [63:0] hr_path_br,
  output logic        jtb_valid,
  output logic        jtb_hit,
  output logic [31:0] jtb_target
);
  function automatic logic [IDX_W-1:0] fold(input logic [63:0] p);
    logic [IDX_W-1:0] f;
    f = '0;
    for (int i = 0; i < 64; i++) f[i % IDX_W] ^= p[i];
    return f;
  endfunction

  logic             v_q [ENTRIES];
  logic [1:0]       c_q [ENTRIES];
  logic [TAG_W-1:0] t_q [ENTRIES];
  logic [29:0]      g_q [ENTRIES];

  logic [IDX_W-1:0] lidx, uidx;
  logic [TAG_W-1:0] ltag, utag;
  logic             lhit, match, same, alloc, repl;
  logic [1:0]       uc, conf_d;
  logic             valid_q, hit_q;
  logic [31:0]      target_q;
  logic             unused_bits;

  assign lidx = fe_pc[IDX_W+1:2] ^ fold(hr_path_bt);
  assign ltag = fe_pc[IDX_W+TAG_W+1:IDX_W+2] ^ hr_path_bt[TAG_W-1:0];
  assign uidx = br_pc[IDX_W+1:2] ^ fold(hr_path_br);
  assign utag = br_pc[IDX_W+TAG_W+1:IDX_W+2] ^ hr_path_br[TAG_W-1:0];
  assign unused_bits = ^{fe_pc[31:IDX_W+TAG_W+2], fe_pc[1:0], br_pc[31:IDX_W+TAG_W+2],
                         br_pc[1:0], br_target[1:0]};

  assign lhit = fe_valid & v_q[lidx] & (t_q[lidx] == ltag) & (c_q[lidx] != 2'd0);

  // Replacement policy: confidence decays on disagreement, entry/target only replaced at conf 0.
  always_comb begin
    uc     = c_q[uidx];
    match  = v_q[uidx] & (t_q[uidx] == utag);
    same   = g_q[uidx] == br_target[31:2];
    alloc  = !v_q[uidx] | (!match & (uc == 2'd0));
    repl   = match & !same & (uc == 2'd0);
    conf_d = (alloc | repl) ? 2'd1 :
             (match & same) ? ((uc == 2'd3) ? 2'd3 : uc + 2'd1) : uc - 2'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        v_q[i] <= 1'b0;
        c_q[i] <= 2'd0;
      end
    end else if (br_jrop) begin
      v_q[uidx] <= 1'b1;
      c_q[uidx] <= conf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (br_jrop & alloc) t_q[uidx] <= utag;
    if (br_jrop & (alloc | repl)) g_q[uidx] <= br_target[31:2];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      hit_q    <= 1'b0;
      target_q <= '0;
    end else if (br_cancel | wb_cancel) begin
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
    end else if (pc_go) begin
      valid_q  <= fe_valid;
      hit_q    <= lhit;
      target_q <= lhit ? {g_q[lidx], 2'b00} : 32'd0;
    end
  end

  assign jtb_valid  = valid_q;
  assign jtb_hit    = hit_q;
  assign jtb_target = target_q;
endmodule

// File: doc/gs232c_jtb.md
Name: gs232c_jtb

Overview:
- Path-indexed indirect-jump target buffer that predicts the targets of jr-class (register-indirect) jumps at fetch.
- Sits directly downstream of the jump history register.
  - Lookup uses the speculative fetch-side path (hr_path_bt).
  - Training uses the branch-resolution path (hr_path_br) and the resolved target of each jr op.
- The prediction is registered and feeds the next-PC mux one cycle after fetch.

Parameters:
- ENTRIES, 64, number of table entries; power of two.
- IDX_W, 6, log2(ENTRIES).
- TAG_W, 8, partial tag width.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- pc_go  in  1  fetch stage advances this cycle.
- fe_valid  in  1  fetch PC valid.
- fe_pc  in  32  fetch PC.
- hr_path_bt  in  64  speculative jr path history.
- br_cancel  in  1  branch-stage redirect.
- wb_cancel  in  1  writeback-stage redirect.
- br_jrop  in  1  a jr op resolved at branch stage this cycle (update strobe).
- br_pc  in  32  PC of the resolved jr.
- br_target  in  32  resolved jr target.
- hr_path_br  in  64  path history corresponding to br_pc.
- jtb_valid  out  1  registered prediction valid.
- jtb_hit  out  1  prediction usable.
- jtb_target  out  32  predicted target; bits [1:0] always 0.

Behaviour:
- Hash, identical for lookup and update; P = path, A = pc.
  - fold(P) = XOR of consecutive IDX_W-bit slices P[IDX_W-1:0], P[2*IDX_W-1:IDX_W], …; the final partial slice is zero-extended.
  - idx = A[IDX_W+1:2] ^ fold(P).
  - tag = A[IDX_W+TAG_W+1:IDX_W+2] ^ P[TAG_W-1:0].
- Entry fields: valid(1), tag(TAG_W), target[31:2](30), conf(2). Storage is flops.
- Reset (reset=0, async):
  - All valid and conf cleared; tag and target left unreset.
  - jtb_valid=0, jtb_hit=0, jtb_target=0.
  - Reset asserted mid-lookup or mid-update discards both.
- Lookup, latency 1:
  - When pc_go=1, the output register loads:
    - jtb_valid <= fe_valid.
    - jtb_hit <= fe_valid & valid & (tag==tag_in) & (conf!=0).
    - jtb_target <= {entry.target, 2'b00}; 0 when not hit.
  - When pc_go=0, outputs hold. Later table updates do not alter held outputs.
- Cancel: br_cancel|wb_cancel clears jtb_valid and jtb_hit next cycle. Cancel beats a same-cycle pc_go load.
- Update: on br_jrop, the entry at idx(br_pc, hr_path_br) is written at the clock edge.
  - Tag match, same target: conf = min(conf+1, 3).
  - Tag match, different target, conf!=0: conf -= 1; target unchanged.
  - Tag match, different target, conf==0: target = br_target, conf = 1.
  - Invalid entry, or tag mismatch with conf==0: allocate. valid=1, tag, target, conf=1.
  - Tag mismatch, conf!=0: conf -= 1; no allocation.
- Updates are not gated by cancel: a br_jrop in the same cycle as br_cancel or wb_cancel still trains.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update entry. No bypass.
- Only one update per cycle. There is no update handshake: br_jrop is a single-cycle strobe.

Test Plan:
- Release reset; pc_go=1, fe_valid=1, fe_pc=0x10000040, hr_path_bt=0 → next cycle jtb_valid=1, jtb_hit=0, jtb_target=0.
- Update br_pc=0x10000040, hr_path_br=0, br_target=0x20000100 (idx 0x10, tag 0x00, conf→1). Repeat the lookup above → jtb_hit=1, jtb_target=0x20000100.
- Same entry, update with br_target=0x20000200 → conf 1→0, lookup jtb_hit=0. Update again with 0x20000200 → target replaced, conf=1, lookup hits 0x20000200. Two more 0x20000200 updates → conf saturates at 3.
- Lookup fe_pc=0x10000040 with hr_path_bt=0x1 → idx 0x11, tag 0x01, jtb_hit=0. Then update with hr_path_br=0x1 → hit, and the idx 0x10 entry is unaffected.
- Hit loaded, then pc_go=0 for 3 cycles while updating the same entry to a new target → outputs hold the old target. Assert br_cancel alone → jtb_valid=0, jtb_hit=0. Assert wb_cancel together with pc_go=1 → jtb_valid=0.
- Train several entries, then pulse reset=0 mid-cycle (asynchronous, between clock edges) → outputs go to 0 immediately; after release, every prior entry misses.
- Lookup and update to the same index in the same cycle → output reflects the old entry, and the next lookup reflects the new one.
